ip_tx_arbiter: RTL and testbench

Two-requester arbiter that shares the single IP transmit datapath between the UDP sender and the ICMP responder. It grants one requester at a time and forwards that requester's payload stream, length and IP protocol type to the IP transmit path. It then enforces an inter-frame hold-off so the IP transmit path finishes emitting the 20-byte header and the payload before the next frame starts. It sits between the UDP/ICMP layers and the IP transmit path.

---
 rtl/ip_tx_pkg.sv | 19 +
 rtl/ip_tx_rr_pick.sv | 34 +++
 rtl/ip_tx_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ip_tx_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_tx_pkg.sv
// Shared definitions for the IP transmit arbiter: protocol numbers, IP header
// length, FSM state encoding and requester bit positions.
package ip_tx_pkg;

  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam logic [7:0]  IP_PROTO_ICMP = 8'd1;
  localparam int unsigned IP_HDR_LEN    = 20;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_WAIT_FIRST = 2'd1;
  localparam state_t ST_XFER       = 2'd2;
  localparam state_t ST_GAP        = 2'd3;

  // Bit positions in the request/select vectors.
  localparam int unsigned REQ_UDP  = 0;
  localparam int unsigned REQ_ICMP = 1;

endpackage

// File: rtl/ip_tx_rr_pick.sv
// Two-way requester selector producing a one-hot select. Default build is
// round-robin; defining ICMP_PRIO_EN gives ICMP fixed priority instead.
module ip_tx_rr_pick
  import ip_tx_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,  // high: ICMP has the turn on a tie
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = 2'b00;
`ifdef ICMP_PRIO_EN
    if (req_i[REQ_ICMP]) begin
      sel_o[REQ_ICMP] = 1'b1;
    end else if (req_i[REQ_UDP]) begin
      sel_o[REQ_UDP] = 1'b1;
    end
`else
    if (req_i[REQ_UDP] && req_i[REQ_ICMP]) begin
      sel_o[REQ_ICMP] = ptr_i;
      sel_o[REQ_UDP]  = ~ptr_i;
    end else begin
      sel_o = req_i;
    end
`endif
  end

`ifdef ICMP_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ptr_i;
`endif

endmodule

// File: rtl/ip_tx_arbiter.sv
// Shares the IP transmit path between the UDP sender and ICMP responder, then
// holds off for the header time. ICMP_PRIO_EN selects fixed ICMP priority.
module ip_tx_arbiter
  import ip_tx_pkg::*;
#(
  parameter logic [7:0]  P_TYPE_UDP  = IP_PROTO_UDP,
  parameter logic [7:0]  P_TYPE_ICMP = IP_PROTO_ICMP,
  parameter int unsigned P_GAP       = IP_HDR_LEN + 4,
  parameter int unsigned P_TIMEOUT   = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_udp_req,
  input  logic [15:0] i_udp_len,
  input  logic [7:0]  i_udp_data,
  input  logic        i_udp_last,
  input  logic        i_udp_valid,
  output logic        o_udp_grant,
  input  logic        i_icmp_req,
  input  logic [15:0] i_icmp_len,
  input  logic [7:0]  i_icmp_data,
  input  logic        i_icmp_last,
  input  logic        i_icmp_valid,
  output logic        o_icmp_grant,
  output logic [7:0]  o_send_data,
  output logic [7:0]  o_send_type,
  output logic [15:0] o_send_len,
  output logic        o_send_last,
  output logic        o_send_valid,
  output logic        o_busy,
  output logic        o_len_err,
  output logic        o_timeout
);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;  // 1: ICMP owns the datapath
  logic        ptr_q, ptr_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  type_q, type_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        last_q, last_d;
  logic        valid_q, valid_d;
  logic        len_err_q, len_err_d;
  logic        timeout_q, timeout_d;

  logic [1:0]  sel;
  logic        own_req, own_valid, own_last, granted, accept;
  logic [7:0]  own_data;
  logic [15:0] cnt_next;

  ip_tx_rr_pick u_pick (
    .req_i ({i_icmp_req, i_udp_req}),
    .ptr_i (ptr_q),
    .sel_o (sel)
  );

  assign own_req   = owner_q ? i_icmp_req   : i_udp_req;
  assign own_valid = owner_q ? i_icmp_valid : i_udp_valid;
  assign own_last  = owner_q ? i_icmp_last  : i_udp_last;
  assign own_data  = owner_q ? i_icmp_data  : i_udp_data;
  assign granted   = (state_q == ST_WAIT_FIRST) || (state_q == ST_XFER);
  assign accept    = granted && own_valid;
  assign cnt_next  = byte_cnt_q + 16'd1;

  // NOTE: every _d gets a default first so no path leaves it unassigned;
  // a missing default here would infer a latch.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    type_d     = type_q;
    byte_cnt_d = byte_cnt_q;
    cnt_d      = cnt_q;
    data_d     = 8'h00;
    last_d     = 1'b0;
    valid_d    = 1'b0;
    len_err_d  = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|sel) begin
          owner_d    = sel[REQ_ICMP];
          len_d      = sel[REQ_ICMP] ? i_icmp_len : i_udp_len;
          type_d     = sel[REQ_ICMP] ? P_TYPE_ICMP : P_TYPE_UDP;
          byte_cnt_d = 16'd0;
          cnt_d      = 8'd0;
          state_d    = ST_WAIT_FIRST;
        end
      end
      ST_WAIT_FIRST: begin
        if (!own_valid) begin
          if (!own_req) begin
            state_d = ST_IDLE;
          end else if (cnt_q == 8'(P_TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_XFER: ;
      ST_GAP: begin
        if (cnt_q == 8'(P_GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A first byte that is also last skips XFER and goes straight to the hold-off.
    if (accept) begin
      data_d     = own_data;
      valid_d    = 1'b1;
      last_d     = own_last;
      byte_cnt_d = cnt_next;
      state_d    = ST_XFER;
      if (own_last) begin
        len_err_d = (cnt_next != len_q);
        ptr_d     = ~owner_q;
        cnt_d     = 8'd0;
        state_d   = ST_GAP;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking is reserved for the combinational block.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      ptr_q      <= 1'b0;
      len_q      <= 16'd0;
      type_q     <= 8'd0;
      byte_cnt_q <= 16'd0;
      cnt_q      <= 8'd0;
      data_q     <= 8'd0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      len_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      type_q     <= type_d;
      byte_cnt_q <= byte_cnt_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
      len_err_q  <= len_err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_udp_grant  = granted && !owner_q;
  assign o_icmp_grant = granted && owner_q;
  assign o_send_data  = data_q;
  assign o_send_type  = type_q;
  assign o_send_len   = len_q;
  assign o_send_last  = last_q;
  assign o_send_valid = valid_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_len_err    = len_err_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Self-checking bench for ip_tx_arbiter: directed scenarios followed by
// randomized frames checked against a frame-level scoreboard and arbitration model.
module tb_ip_tx_arbiter;

  localparam int P_GAP     = 24;
  localparam int P_TIMEOUT = 255;
  localparam logic [7:0] T_UDP  = 8'd17;
  localparam logic [7:0] T_ICMP = 8'd1;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_udp_req, i_udp_last, i_udp_valid;
  logic [15:0] i_udp_len;
  logic [7:0]  i_udp_data;
  logic        i_icmp_req, i_icmp_last, i_icmp_valid;
  logic [15:0] i_icmp_len;
  logic [7:0]  i_icmp_data;
  logic        o_udp_grant, o_icmp_grant;
  logic [7:0]  o_send_data, o_send_type;
  logic [15:0] o_send_len;
  logic        o_send_last, o_send_valid, o_busy, o_len_err, o_timeout;

  ip_tx_arbiter #(.P_GAP(P_GAP), .P_TIMEOUT(P_TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_udp_req(i_udp_req), .i_udp_len(i_udp_len), .i_udp_data(i_udp_data),
    .i_udp_last(i_udp_last), .i_udp_valid(i_udp_valid), .o_udp_grant(o_udp_grant),
    .i_icmp_req(i_icmp_req), .i_icmp_len(i_icmp_len), .i_icmp_data(i_icmp_data),
    .i_icmp_last(i_icmp_last), .i_icmp_valid(i_icmp_valid), .o_icmp_grant(o_icmp_grant),
    .o_send_data(o_send_data), .o_send_type(o_send_type), .o_send_len(o_send_len),
    .o_send_last(o_send_last), .o_send_valid(o_send_valid), .o_busy(o_busy),
    .o_len_err(o_len_err), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic [7:0]  typ;
    logic [15:0] len;
    logic        len_err;
    int          cyc;
  } exp_t;

  typedef struct {
    bit who;
    int cyc;
  } rise_t;

  exp_t  sb_q[$];
  rise_t rise_q[$];
  int    last_cyc_q[$];
  exp_t  mon_e;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int busy_fall_cyc = 0;
  int len_err_cnt = 0;
  int timeout_cnt = 0;
  bit mon_en = 1'b0;
  bit prev_udp_g = 1'b0, prev_icmp_g = 1'b0, prev_busy = 1'b0;
  bit last_served = 1'b1;  // "ICMP served last" makes UDP win the first tie

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Arbitration rule: lone requester wins; a tie goes to the one not served last.
  function automatic bit model_pick(input bit udp, input bit icmp);
    if (udp && !icmp) return 1'b0;
    if (icmp && !udp) return 1'b1;
`ifdef ICMP_PRIO_EN
    return 1'b1;
`else
    return (last_served == 1'b0);
`endif
  endfunction

  always @(negedge i_clk) begin
    if (mon_en) begin
      check("grant_excl", 32'(o_udp_grant & o_icmp_grant), 32'd0);
      if (o_udp_grant && !prev_udp_g) rise_q.push_back('{1'b0, cyc});
      if (o_icmp_grant && !prev_icmp_g) rise_q.push_back('{1'b1, cyc});
      if (prev_busy && !o_busy) busy_fall_cyc = cyc;
      if (o_len_err) len_err_cnt++;
      if (o_timeout) timeout_cnt++;
      if (o_send_valid) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $error("FAIL unexpected_byte: observed data 0x%0h with nothing expected", o_send_data);
        end else begin
          mon_e = sb_q.pop_front();
          check("send_data", 32'(o_send_data), 32'(mon_e.data));
          check("send_last", 32'(o_send_last), 32'(mon_e.last));
          check("send_type", 32'(o_send_type), 32'(mon_e.typ));
          check("send_len", 32'(o_send_len), 32'(mon_e.len));
          check("len_err", 32'(o_len_err), 32'(mon_e.len_err));
          check("latency", 32'(cyc), 32'(mon_e.cyc));
          if (o_send_last) last_cyc_q.push_back(cyc);
        end
      end else begin
        check("len_err_idle", 32'(o_len_err), 32'd0);
      end
    end
    prev_udp_g  = o_udp_grant;
    prev_icmp_g = o_icmp_grant;
    prev_busy   = o_busy;
  end

  task automatic set_in(input bit who, input logic req, input logic [15:0] len,
                        input logic [7:0] d, input logic last, input logic valid);
    if (who) begin
      i_icmp_req = req; i_icmp_len = len; i_icmp_data = d; i_icmp_last = last; i_icmp_valid = valid;
    end else begin
      i_udp_req = req; i_udp_len = len; i_udp_data = d; i_udp_last = last; i_udp_valid = valid;
    end
  endtask

  task automatic wait_grant(input bit who, output bit ok);
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!(who ? o_icmp_grant : o_udp_grant) && n < 2000);
    ok = who ? o_icmp_grant : o_udp_grant;
    if (!ok) begin
      n_total++;
      $error("FAIL %s: observed no grant after %0d cycles, expected a grant",
             who ? "icmp_grant_wait" : "udp_grant_wait", n);
    end
  endtask

  // Request, wait for grant, then stream nbytes contiguous bytes base, base+1, ...
  task automatic run_req(input bit who, input logic [15:0] len, input int nbytes,
                         input int delay, input logic [7:0] base);
    bit   ok;
    exp_t e;
    set_in(who, 1'b1, len, 8'h00, 1'b0, 1'b0);
    wait_grant(who, ok);
    if (!ok) begin
      set_in(who, 1'b0, len, 8'h00, 1'b0, 1'b0);
      return;
    end
    repeat (delay) @(negedge i_clk);
    for (int i = 0; i < nbytes; i++) begin
      if (i > 0) @(negedge i_clk);
      e.data    = base + 8'(i);
      e.last    = (i == nbytes - 1);
      e.typ     = who ? T_ICMP : T_UDP;
      e.len     = len;
      e.len_err = e.last && (nbytes != int'(len));
      e.cyc     = cyc + 1;
      sb_q.push_back(e);
      set_in(who, 1'b0, len, e.data, e.last, 1'b1);
    end
    @(negedge i_clk);
    set_in(who, 1'b0, len, 8'h00, 1'b0, 1'b0);
    last_served = who;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    if (o_busy) begin
      n_total++;
      $error("FAIL idle_wait: observed busy after %0d cycles, expected idle", n);
    end
    @(negedge i_clk);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_udp_grant"}, 32'(o_udp_grant), 32'd0);
    check({pfx, "_icmp_grant"}, 32'(o_icmp_grant), 32'd0);
    check({pfx, "_data"}, 32'(o_send_data), 32'd0);
    check({pfx, "_type"}, 32'(o_send_type), 32'd0);
    check({pfx, "_len"}, 32'(o_send_len), 32'd0);
    check({pfx, "_last"}, 32'(o_send_last), 32'd0);
    check({pfx, "_valid"}, 32'(o_send_valid), 32'd0);
    check({pfx, "_busy"}, 32'(o_busy), 32'd0);
    check({pfx, "_len_err"}, 32'(o_len_err), 32'd0);
    check({pfx, "_timeout"}, 32'(o_timeout), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    bit   ok, exp_first;
    int   n, err0, to0, mode, l0, l1, nb0, nb1, d0, d1;
    exp_t e;

    i_rst = 1'b1;
    set_in(1'b0, 1'b0, 16'd0, 8'h00, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 16'd0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge i_clk);
    check_all_zero("reset");
    i_rst  = 1'b0;
    mon_en = 1'b1;
    @(negedge i_clk);

    // Single UDP frame, then measure the hold-off.
    run_req(1'b0, 16'd8, 8, 0, 8'h01);
    check("gap_type_hold", 32'(o_send_type), 32'(T_UDP));
    check("gap_len_hold", 32'(o_send_len), 32'd8);
    check("gap_busy", 32'(o_busy), 32'd1);
    wait_idle();
    if (last_cyc_q.size() > 0) check("gap_cycles", 32'(busy_fall_cyc - last_cyc_q[$]), 32'(P_GAP));

    // Simultaneous requests.
    rise_q.delete();
    last_cyc_q.delete();
    exp_first = model_pick(1'b1, 1'b1);
    fork
      run_req(1'b0, 16'd4, 4, 0, 8'h10);
      run_req(1'b1, 16'd4, 4, 0, 8'h20);
    join
    wait_idle();
    check("pair_grants", 32'(rise_q.size()), 32'd2);
    if (rise_q.size() >= 2 && last_cyc_q.size() >= 1) begin
      check("pair_first", 32'(rise_q[0].who), 32'(exp_first));
      check("pair_second_delay", 32'(rise_q[1].cyc - last_cyc_q[0]), 32'(P_GAP + 1));
    end

    // Length mismatch and zero-length frame.
    run_req(1'b1, 16'd10, 6, 1, 8'h30);
    wait_idle();
    run_req(1'b0, 16'd0, 1, 2, 8'hA5);
    wait_idle();

    // Timeout with an ICMP request pending.
    to0 = timeout_cnt;
    set_in(1'b0, 1'b1, 16'd4, 8'h00, 1'b0, 1'b0);
    fork
      begin
        wait_grant(1'b0, ok);
        n = 0;
        while (o_udp_grant && n < 400) begin
          n++;
          @(negedge i_clk);
        end
        check("timeout_grant_cycles", 32'(n), 32'(P_TIMEOUT));
        check("timeout_pulse", 32'(o_timeout), 32'd1);
        check("timeout_grant_low", 32'(o_udp_grant), 32'd0);
        set_in(1'b0, 1'b0, 16'd4, 8'h00, 1'b0, 1'b0);
        @(negedge i_clk);
        check("timeout_pulse_end", 32'(o_timeout), 32'd0);
        check("timeout_icmp_next", 32'(o_icmp_grant), 32'd1);
      end
      begin
        repeat (5) @(negedge i_clk);
        run_req(1'b1, 16'd3, 3, 0, 8'h40);
      end
    join
    wait_idle();
    check("timeout_count", 32'(timeout_cnt - to0), 32'd1);

    // Request withdrawn before the first byte.
    err0 = len_err_cnt;
    to0  = timeout_cnt;
    set_in(1'b0, 1'b1, 16'd5, 8'h00, 1'b0, 1'b0);
    wait_grant(1'b0, ok);
    set_in(1'b0, 1'b0, 16'd5, 8'h00, 1'b0, 1'b0);
    @(negedge i_clk);
    check("withdraw_grant", 32'(o_udp_grant), 32'd0);
    check("withdraw_busy", 32'(o_busy), 32'd0);
    repeat (3) @(negedge i_clk);
    check("withdraw_len_err", 32'(len_err_cnt - err0), 32'd0);
    check("withdraw_timeout", 32'(timeout_cnt - to0), 32'd0);

    // Reset while the third byte of an 8-byte frame is presented.
    set_in(1'b0, 1'b1, 16'd8, 8'h00, 1'b0, 1'b0);
    wait_grant(1'b0, ok);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge i_clk);
      if (i == 2) begin
        i_rst = 1'b1;
      end else begin
        e.data = 8'h61 + 8'(i); e.last = 1'b0; e.typ = T_UDP; e.len = 16'd8;
        e.len_err = 1'b0; e.cyc = cyc + 1;
        sb_q.push_back(e);
      end
      set_in(1'b0, 1'b0, 16'd8, 8'h61 + 8'(i), 1'b0, 1'b1);
    end
    @(negedge i_clk);
    check_all_zero("midrst");
    check("midrst_sb_empty", 32'(sb_q.size()), 32'd0);
    i_rst = 1'b0;
    set_in(1'b0, 1'b0, 16'd0, 8'h00, 1'b0, 1'b0);
    last_served = 1'b1;
    @(negedge i_clk);
    run_req(1'b0, 16'd5, 5, 0, 8'h70);
    wait_idle();

    // Randomized frames: single requesters and ties.
    for (int k = 0; k < 24; k++) begin
      mode = $urandom_range(0, 2);
      l0   = $urandom_range(1, 12);
      l1   = $urandom_range(1, 12);
      nb0  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : l0;
      nb1  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : l1;
      d0   = $urandom_range(0, 3);
      d1   = $urandom_range(0, 3);
      if (mode == 2) begin
        rise_q.delete();
        exp_first = model_pick(1'b1, 1'b1);
        fork
          run_req(1'b0, 16'(l0), nb0, d0, 8'($urandom));
          run_req(1'b1, 16'(l1), nb1, d1, 8'($urandom));
        join
        if (rise_q.size() > 0) check("rand_tie_first", 32'(rise_q[0].who), 32'(exp_first));
      end else begin
        run_req(mode == 1, 16'(l0), nb0, d0, 8'($urandom));
      end
      wait_idle();
    end

    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
